// File: rtl/nmc_pkg.sv
// Shared constants and helpers for the MAC subarray datapath.
//   NMC_WIDTH / NMC_DEPTH : default data width and pipeline depth
//   sel_w()               : width of a field able to hold 0..depth
package nmc_pkg;

  localparam int NMC_WIDTH = 8;
  localparam int NMC_DEPTH = 4;

  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_pipe_if.sv
// Data/tap bundle of the dff_pipe delay line.
//   master : drives d, d_valid, dly_sel; observes q, q_valid, busy, vld_cnt
//   slave  : the pipeline itself
interface dff_pipe_if
  import nmc_pkg::*;
#(
  parameter int WIDTH = NMC_WIDTH,
  parameter int SELW  = sel_w(NMC_DEPTH)
);

  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic [SELW-1:0]  dly_sel;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             busy;
  logic [SELW-1:0]  vld_cnt;

  modport master (
    output d, d_valid, dly_sel,
    input  q, q_valid, busy, vld_cnt
  );

  modport slave (
    input  d, d_valid, dly_sel,
    output q, q_valid, busy, vld_cnt
  );

endinterface

// File: rtl/dff_pipe_stage.sv
// One stage of the delay line: WIDTH data bits plus a valid bit.
//   sys_clk, rst_n : clock, synchronous active-low reset
//   en             : advance enable (0 = hold)
//   flush          : clear valid (and data when CLR_DATA=1), ignores en
//   d_in, v_in     : previous stage (or pipe input)
//   d_out, v_out   : registered stage contents
module dff_pipe_stage
  import nmc_pkg::*;
#(
  parameter int WIDTH    = NMC_WIDTH,
  parameter bit CLR_DATA = 1'b1
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d_in,
  input  logic             v_in,
  output logic [WIDTH-1:0] d_out,
  output logic             v_out
);

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      d_out <= '0;
      v_out <= 1'b0;
    end else if (flush) begin
      v_out <= 1'b0;
      if (CLR_DATA) d_out <= '0;
    end else if (en) begin
      d_out <= d_in;
      v_out <= v_in;
    end
  end

endmodule

// File: rtl/dff_pipe.sv
// WIDTH-bit, DEPTH-stage register pipeline with per-stage valids, global
// stall, synchronous flush and a runtime-selectable output tap.
//   sys_clk, rst_n : clock, synchronous active-low reset
//   sys_en         : advance enable (0 = stall, all state holds)
//   flush          : clear all stage valids (and data when CLR_DATA=1)
//   bus.d/d_valid  : input item
//   bus.dly_sel    : requested delay 0..DEPTH (larger values saturate)
//   bus.q/q_valid  : item at the selected tap (0 = combinational bypass)
//   bus.busy       : any stage holds a valid item
//   bus.vld_cnt    : number of stages holding valid items
module dff_pipe
  import nmc_pkg::*;
#(
  parameter int WIDTH    = NMC_WIDTH,
  parameter int DEPTH    = NMC_DEPTH,
  parameter int SELW     = sel_w(DEPTH),
  parameter int RST_DLY  = DEPTH,
  parameter bit CLR_DATA = 1'b1
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       sys_en,
  input  logic       flush,
  dff_pipe_if.slave  bus
);

  // Index 0 is the pipe input; 1..DEPTH are the registered stages.
  logic [WIDTH-1:0] data_p [DEPTH+1];
  logic [DEPTH:0]   vld_p;
  logic [SELW-1:0]  dly_r;
  logic [SELW-1:0]  cnt_r;

  function automatic logic [SELW-1:0] sat_sel(input logic [SELW-1:0] s);
    if (int'(s) > DEPTH) return SELW'(DEPTH);
    return s;
  endfunction

  assign data_p[0] = bus.d;
  assign vld_p[0]  = bus.d_valid;

  // ---- register stages 1..DEPTH ----
  for (genvar i = 1; i <= DEPTH; i++) begin : g_stage
    dff_pipe_stage #(
      .WIDTH    (WIDTH),
      .CLR_DATA (CLR_DATA)
    ) u_stage (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .en      (sys_en),
      .flush   (flush),
      .d_in    (data_p[i-1]),
      .v_in    (vld_p[i-1]),
      .d_out   (data_p[i]),
      .v_out   (vld_p[i])
    );
  end

  assign bus.busy    = |vld_p[DEPTH:1];
  assign bus.vld_cnt = cnt_r;

  // The tap only moves while the pipe is empty, so a retarget can never
  // skip or repeat an in-flight item.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      dly_r <= SELW'(RST_DLY);
    end else if (sys_en && !bus.busy) begin
      dly_r <= sat_sel(bus.dly_sel);
    end
  end

  // Incremental popcount: one in at stage 1, one out past stage DEPTH.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (flush) begin
      cnt_r <= '0;
    end else if (sys_en) begin
      cnt_r <= cnt_r + SELW'(bus.d_valid) - SELW'(vld_p[DEPTH]);
    end
  end

  // ---- output tap ----
  always_comb begin
    bus.q       = bus.d;
    bus.q_valid = bus.d_valid & sys_en & ~flush;
    if (dly_r != '0) begin
      bus.q       = data_p[dly_r];
      bus.q_valid = vld_p[dly_r];
    end
  end

endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe (WIDTH=8, DEPTH=4, CLR_DATA=1).
// A reference queue of in-flight items with their stage age predicts
// q/q_valid/busy/vld_cnt every cycle; a vector table and hand-written
// sequences cover latency, stall, flush, select guard, saturation, bypass.
module tb_dff_pipe;

  localparam int DEPTH = 4;

  logic sys_clk;
  logic rst_n;
  logic sys_en;
  logic flush;

  dff_pipe_if #(.WIDTH(8), .SELW(3)) bus ();

  dff_pipe #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .sys_en  (sys_en),
    .flush   (flush),
    .bus     (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [7:0] data;
    int         age;
  } item_t;

  typedef struct {
    bit         en;
    bit         fl;
    bit         dv;
    logic [7:0] d;
    logic [2:0] sel;
    bit         eqv;
    logic [7:0] eq;
    bit         ebusy;
    logic [2:0] ecnt;
  } vec_t;

  item_t sb_q[$];
  int    dly_m;
  int    n_tests;
  int    n_fail;

  logic       last_qv;
  logic [7:0] last_q;
  logic       last_busy;
  logic [2:0] last_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle: inputs set just after a rising edge, outputs checked
  // against the reference at the falling edge, reference advanced at the
  // next rising edge.
  task automatic apply(input bit en, input bit fl, input bit dv,
                       input logic [7:0] dd, input logic [2:0] sel);
    bit         exp_qv;
    logic [7:0] exp_q;
    bit         idle;
    sys_en      = en;
    flush       = fl;
    bus.d       = dd;
    bus.d_valid = dv;
    bus.dly_sel = sel;
    @(negedge sys_clk);
    exp_qv = 1'b0;
    exp_q  = 8'h00;
    if (dly_m == 0) begin
      exp_qv = dv & en & ~fl;
      exp_q  = dd;
    end else begin
      foreach (sb_q[i]) begin
        if (sb_q[i].age == dly_m) begin
          exp_qv = 1'b1;
          exp_q  = sb_q[i].data;
        end
      end
    end
    chk("sb_q_valid", 32'(bus.q_valid), 32'(exp_qv));
    if (exp_qv) chk("sb_q", 32'(bus.q), 32'(exp_q));
    chk("sb_busy", 32'(bus.busy), 32'(sb_q.size() != 0));
    chk("sb_vld_cnt", 32'(bus.vld_cnt), 32'(sb_q.size()));
    last_qv   = bus.q_valid;
    last_q    = bus.q;
    last_busy = bus.busy;
    last_cnt  = bus.vld_cnt;
    @(posedge sys_clk);
    idle = (sb_q.size() == 0);
    if (en && idle) dly_m = (int'(sel) > DEPTH) ? DEPTH : int'(sel);
    if (fl) begin
      sb_q.delete();
    end else if (en) begin
      foreach (sb_q[i]) sb_q[i].age++;
      while (sb_q.size() > 0 && sb_q[0].age > DEPTH) void'(sb_q.pop_front());
      if (dv) sb_q.push_back('{data: dd, age: 1});
    end
    #1;
  endtask

  vec_t tbl [9];

  initial begin
    int seen_at;
    int seen_cnt;
    n_tests = 0;
    n_fail  = 0;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd3, 1'b0, 8'h00, 1'b0, 3'd0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 8'h11, 3'd3, 1'b0, 8'h00, 1'b0, 3'd0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 8'h22, 3'd3, 1'b0, 8'h00, 1'b1, 3'd1};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 8'h33, 3'd3, 1'b0, 8'h00, 1'b1, 3'd2};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd3, 1'b1, 8'h11, 1'b1, 3'd3};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd3, 1'b1, 8'h22, 1'b1, 3'd3};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd3, 1'b1, 8'h33, 1'b1, 3'd2};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd3, 1'b0, 8'h00, 1'b1, 3'd1};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd3, 1'b0, 8'h00, 1'b0, 3'd0};

    // Reset with a valid input presented: nothing may be captured.
    rst_n       = 1'b0;
    sys_en      = 1'b1;
    flush       = 1'b0;
    bus.d       = 8'hAA;
    bus.d_valid = 1'b1;
    bus.dly_sel = 3'd4;
    repeat (2) @(posedge sys_clk);
    #1;
    @(negedge sys_clk);
    chk("rst_q", 32'(bus.q), 32'h0);
    chk("rst_q_valid", 32'(bus.q_valid), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_vld_cnt", 32'(bus.vld_cnt), 32'h0);
    @(posedge sys_clk);
    #1;
    rst_n = 1'b1;
    sb_q.delete();
    dly_m = DEPTH;

    // Single item at the reset delay of 4.
    apply(1'b1, 1'b0, 1'b1, 8'h99, 3'd4);
    for (int i = 0; i < 6; i++) apply(1'b1, 1'b0, 1'b0, 8'h00, 3'd4);

    // Basic latency table, delay 3.
    for (int i = 0; i < 9; i++) begin
      apply(tbl[i].en, tbl[i].fl, tbl[i].dv, tbl[i].d, tbl[i].sel);
      chk($sformatf("tbl%0d_q_valid", i), 32'(last_qv), 32'(tbl[i].eqv));
      if (tbl[i].eqv) chk($sformatf("tbl%0d_q", i), 32'(last_q), 32'(tbl[i].eq));
      chk($sformatf("tbl%0d_busy", i), 32'(last_busy), 32'(tbl[i].ebusy));
      chk($sformatf("tbl%0d_vld_cnt", i), 32'(last_cnt), 32'(tbl[i].ecnt));
    end

    // Stall mid-flight at delay 2: three stalled cycles add three cycles.
    apply(1'b1, 1'b0, 1'b0, 8'h00, 3'd2);
    apply(1'b1, 1'b0, 1'b1, 8'h5A, 3'd2);
    seen_at  = -1;
    seen_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 3) apply(1'b0, 1'b0, 1'b1, 8'hEE, 3'd2);
      else       apply(1'b1, 1'b0, 1'b0, 8'h00, 3'd2);
      if (last_qv) begin
        seen_cnt++;
        if (seen_at < 0) seen_at = i;
      end
    end
    chk("stall_latency", 32'(seen_at), 32'd4);
    chk("stall_count", 32'(seen_cnt), 32'd1);

    // Flush colliding with a valid input on a full pipe.
    apply(1'b1, 1'b0, 1'b0, 8'h00, 3'd4);
    apply(1'b1, 1'b0, 1'b1, 8'hA1, 3'd4);
    apply(1'b1, 1'b0, 1'b1, 8'hA2, 3'd4);
    apply(1'b1, 1'b0, 1'b1, 8'hA3, 3'd4);
    apply(1'b1, 1'b0, 1'b1, 8'hA4, 3'd4);
    chk("full_vld_cnt", 32'(bus.vld_cnt), 32'd4);
    apply(1'b1, 1'b1, 1'b1, 8'h77, 3'd4);
    apply(1'b1, 1'b0, 1'b0, 8'h00, 3'd4);
    chk("flush_q_zero", 32'(last_q), 32'h0);
    chk("flush_busy", 32'(last_busy), 32'h0);
    chk("flush_vld_cnt", 32'(last_cnt), 32'h0);
    seen_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 1'b0, 1'b0, 8'h00, 3'd4);
      if (last_qv) seen_cnt++;
    end
    chk("flush_dropped", 32'(seen_cnt), 32'd0);

    // Select guard: retarget to 1 while busy keeps the old delay of 4.
    apply(1'b1, 1'b0, 1'b1, 8'hB1, 3'd4);
    apply(1'b1, 1'b0, 1'b0, 8'h00, 3'd1);
    chk("guard_hold_q_valid", 32'(last_qv), 32'h0);
    seen_at = -1;
    for (int i = 1; i < 6; i++) begin
      apply(1'b1, 1'b0, 1'b0, 8'h00, 3'd1);
      if (last_qv && seen_at < 0) seen_at = i;
    end
    chk("guard_old_latency", 32'(seen_at), 32'd3);
    apply(1'b1, 1'b0, 1'b1, 8'h3C, 3'd1);
    apply(1'b1, 1'b0, 1'b0, 8'h00, 3'd1);
    chk("guard_new_q_valid", 32'(last_qv), 32'h1);
    chk("guard_new_q", 32'(last_q), 32'h3C);
    for (int i = 0; i < 4; i++) apply(1'b1, 1'b0, 1'b0, 8'h00, 3'd7);

    // Out-of-range select saturates to the deepest tap.
    apply(1'b1, 1'b0, 1'b1, 8'hC7, 3'd7);
    seen_at = -1;
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 1'b0, 1'b0, 8'h00, 3'd7);
      if (last_qv && seen_at < 0) seen_at = i;
    end
    chk("sat_latency", 32'(seen_at), 32'd3);

    // Bypass at delay 0.
    apply(1'b1, 1'b0, 1'b0, 8'h00, 3'd0);
    apply(1'b1, 1'b0, 1'b1, 8'hD5, 3'd0);
    chk("byp_q_valid", 32'(last_qv), 32'h1);
    chk("byp_q", 32'(last_q), 32'hD5);
    apply(1'b0, 1'b0, 1'b1, 8'hE6, 3'd0);
    chk("byp_stall_q_valid", 32'(last_qv), 32'h0);
    apply(1'b1, 1'b1, 1'b1, 8'hF7, 3'd0);
    chk("byp_flush_q_valid", 32'(last_qv), 32'h0);
    apply(1'b1, 1'b0, 1'b0, 8'h00, 3'd0);
    chk("byp_after_flush_busy", 32'(last_busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
